// File: rtl/core_mem_pkg.sv
// Shared types and widths for the memory-access stage and its LL/SC link monitor.
package core_mem_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int WADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
    return byte_addr[DATA_W-1:2];
  endfunction

endpackage

// File: rtl/core_llsc_monitor.sv
// LL/SC link register: set by a completed LL, checked by SC, cleared by SC,
// by a plain store to the linked word, or by a coherence invalidate.
module core_llsc_monitor
  import core_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_i,
  input  logic [WADDR_W-1:0] set_addr_i,
  input  logic               sc_i,
  input  logic [WADDR_W-1:0] check_addr_i,
  output logic               sc_hit_o,
  input  logic               store_i,
  input  logic [WADDR_W-1:0] store_addr_i,
  input  logic               inv_valid_i,
  input  logic [WADDR_W-1:0] inv_addr_i,
  output logic               link_valid_o,
  output logic [WADDR_W-1:0] link_addr_o
);

  logic               link_valid_q, link_valid_d;
  logic [WADDR_W-1:0] link_addr_q, link_addr_d;
  logic               store_hit_s, inv_hit_s;

  // Invalidate is compared against the post-set address so a same-cycle LL loses.
  assign store_hit_s = store_i && (store_addr_i == link_addr_q);
  assign inv_hit_s   = inv_valid_i && (inv_addr_i == link_addr_d);
  assign sc_hit_o    = link_valid_q && (link_addr_q == check_addr_i);

  always_comb begin
    if (set_i) begin
      link_addr_d = set_addr_i;
    end else begin
      link_addr_d = link_addr_q;
    end
  end

  always_comb begin
    if (sc_i || store_hit_s || inv_hit_s) begin
      link_valid_d = 1'b0;
    end else if (set_i) begin
      link_valid_d = 1'b1;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid_o = link_valid_q;
  assign link_addr_o  = link_addr_q;

endmodule

// File: rtl/core_mem_access.sv
// MEM stage: drives the data-memory req/ack port, stalls upstream while an access
// is outstanding, hosts the LL/SC link monitor and fills the MEM/WB registers.
module core_mem_access
  import core_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_branch,
  input  logic               mem_alu_zero,
  input  logic               mem_mem_read,
  input  logic               mem_mem_write,
  input  logic               mem_ll_mem,
  input  logic               mem_sc_mem,
  input  logic               mem_reg_write,
  input  logic               mem_memtoreg,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [DATA_W-1:0]  mem_reg_read2,
  input  logic [REG_W-1:0]   mem_dest_reg,
  output logic               m_req,
  output logic               m_we,
  output logic [DATA_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  input  logic               m_ack,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               inv_valid,
  input  logic [WADDR_W-1:0] inv_addr,
  output logic               stall,
  output logic               branch_taken,
  output logic               wb_reg_write,
  output logic               wb_memtoreg,
  output logic [DATA_W-1:0]  wb_mem_data,
  output logic [DATA_W-1:0]  wb_alu_result,
  output logic [REG_W-1:0]   wb_dest_reg
);

  state_e state_q, state_d;

  logic [WADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0]  req_wdata_q;
  logic [DATA_W-1:0]  req_alu_q;
  logic [REG_W-1:0]   req_dest_q;
  logic               req_is_ll_q, req_is_sc_q, req_reg_write_q, req_memtoreg_q;

  logic               wb_reg_write_d, wb_memtoreg_d;
  logic [DATA_W-1:0]  wb_mem_data_d, wb_alu_result_d;
  logic [REG_W-1:0]   wb_dest_reg_d;

  logic issue_s, stall_s, sc_hit_s, link_valid_s;
  logic [WADDR_W-1:0] link_addr_s;

  core_llsc_monitor u_llsc (
    .clk          (clk),
    .rst          (rst),
    .set_i        ((state_q == RD_WAIT) && m_ack && req_is_ll_q),
    .set_addr_i   (req_addr_q),
    .sc_i         ((state_q == IDLE) && mem_sc_mem),
    .check_addr_i (word_addr(mem_alu_result)),
    .sc_hit_o     (sc_hit_s),
    .store_i      ((state_q == IDLE) && mem_mem_write),
    .store_addr_i (word_addr(mem_alu_result)),
    .inv_valid_i  (inv_valid),
    .inv_addr_i   (inv_addr),
    .link_valid_o (link_valid_s),
    .link_addr_o  (link_addr_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_mem_read || mem_ll_mem) begin
          state_d = RD_WAIT;
        end else if (mem_mem_write || (mem_sc_mem && sc_hit_s)) begin
          state_d = WR_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (m_ack) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any cycle that stalls loads a bubble; the MEM/WB fields default to it.
  always_comb begin
    issue_s         = 1'b0;
    stall_s         = 1'b0;
    wb_reg_write_d  = 1'b0;
    wb_memtoreg_d   = 1'b0;
    wb_mem_data_d   = 32'h0000_0000;
    wb_alu_result_d = 32'h0000_0000;
    wb_dest_reg_d   = 5'd0;
    case (state_q)
      IDLE: begin
        if (state_d != IDLE) begin
          issue_s = 1'b1;
          stall_s = 1'b1;
        end else begin
          wb_reg_write_d  = mem_reg_write;
          wb_memtoreg_d   = mem_memtoreg | mem_sc_mem;
          wb_alu_result_d = mem_alu_result;
          wb_dest_reg_d   = mem_dest_reg;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (m_ack) begin
          wb_reg_write_d  = req_reg_write_q;
          wb_memtoreg_d   = req_memtoreg_q;
          wb_alu_result_d = req_alu_q;
          wb_dest_reg_d   = req_dest_q;
          if (state_q == RD_WAIT) begin
            wb_mem_data_d = m_rdata;
          end else if (req_is_sc_q) begin
            wb_mem_data_d = 32'h0000_0001;
          end else begin
            wb_mem_data_d = 32'h0000_0000;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      default: stall_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_alu_q       <= '0;
      req_dest_q      <= '0;
      req_is_ll_q     <= 1'b0;
      req_is_sc_q     <= 1'b0;
      req_reg_write_q <= 1'b0;
      req_memtoreg_q  <= 1'b0;
    end else if (issue_s) begin
      req_addr_q      <= word_addr(mem_alu_result);
      req_wdata_q     <= mem_reg_read2;
      req_alu_q       <= mem_alu_result;
      req_dest_q      <= mem_dest_reg;
      req_is_ll_q     <= mem_ll_mem;
      req_is_sc_q     <= mem_sc_mem;
      req_reg_write_q <= mem_reg_write;
      req_memtoreg_q  <= mem_memtoreg | mem_sc_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_mem_data   <= '0;
      wb_alu_result <= '0;
      wb_dest_reg   <= '0;
    end else begin
      wb_reg_write  <= wb_reg_write_d;
      wb_memtoreg   <= wb_memtoreg_d;
      wb_mem_data   <= wb_mem_data_d;
      wb_alu_result <= wb_alu_result_d;
      wb_dest_reg   <= wb_dest_reg_d;
    end
  end

  assign m_req        = (state_q != IDLE);
  assign m_we         = (state_q == WR_WAIT);
  assign m_addr       = {req_addr_q, 2'b00};
  assign m_wdata      = req_wdata_q;
  assign stall        = stall_s && !rst;
  assign branch_taken = mem_branch & mem_alu_zero;

endmodule

// File: tb/tb_core_mem_access.sv
// Directed bench for core_mem_access: loads, stores, LL/SC paths, reset mid-access, branch.
module tb_core_mem_access;

  logic        clk, rst;
  logic        mem_branch, mem_alu_zero;
  logic        mem_mem_read, mem_mem_write, mem_ll_mem, mem_sc_mem;
  logic        mem_reg_write, mem_memtoreg;
  logic [31:0] mem_alu_result, mem_reg_read2;
  logic [4:0]  mem_dest_reg;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        inv_valid;
  logic [29:0] inv_addr;
  logic        stall, branch_taken, wb_reg_write, wb_memtoreg;
  logic [31:0] wb_mem_data, wb_alu_result;
  logic [4:0]  wb_dest_reg;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt;

  core_mem_access dut (
    .clk(clk), .rst(rst),
    .mem_branch(mem_branch), .mem_alu_zero(mem_alu_zero),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_ll_mem(mem_ll_mem), .mem_sc_mem(mem_sc_mem),
    .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_alu_result(mem_alu_result), .mem_reg_read2(mem_reg_read2),
    .mem_dest_reg(mem_dest_reg),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .stall(stall), .branch_taken(branch_taken),
    .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
    .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
    .wb_dest_reg(wb_dest_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_branch = 1'b0; mem_alu_zero = 1'b0;
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_ll_mem = 1'b0; mem_sc_mem = 1'b0;
    mem_reg_write = 1'b0; mem_memtoreg = 1'b0;
    mem_alu_result = 32'h0; mem_reg_read2 = 32'h0; mem_dest_reg = 5'd0;
    m_ack = 1'b0; m_rdata = 32'h0; inv_valid = 1'b0; inv_addr = 30'h0;
  endtask

  // LL with a one-cycle ack; optionally an invalidate arrives in the ack cycle.
  task automatic do_ll(input logic [31:0] addr, input logic inv_same, input logic [29:0] iaddr);
    mem_ll_mem = 1'b1; mem_alu_result = addr; mem_reg_write = 1'b1;
    mem_memtoreg = 1'b1; mem_dest_reg = 5'd3;
    tick();
    m_ack = 1'b1; m_rdata = 32'hAAAA_0001;
    inv_valid = inv_same; inv_addr = iaddr;
    tick();
    idle_inputs();
  endtask

  task automatic set_sc(input logic [31:0] addr, input logic [31:0] data);
    mem_sc_mem = 1'b1; mem_alu_result = addr; mem_reg_read2 = data;
    mem_reg_write = 1'b1; mem_dest_reg = 5'd4;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_wb_mem_data", wb_mem_data, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Load, ack after 3 wait cycles
    mem_mem_read = 1'b1; mem_alu_result = 32'h0000_0104; mem_reg_write = 1'b1;
    mem_memtoreg = 1'b1; mem_dest_reg = 5'd5;
    #1;
    stall_cnt = 0;
    if (stall) stall_cnt++;
    tick();
    chk("ld_m_req", {31'd0, m_req}, 32'd1);
    chk("ld_m_addr", m_addr, 32'h0000_0104);
    chk("ld_m_we", {31'd0, m_we}, 32'd0);
    chk("ld_bubble", {31'd0, wb_reg_write}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      tick();
    end
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_ack", {31'd0, stall}, 32'd0);
    chk("ld_stall_cnt", stall_cnt, 32'd4);
    tick();
    idle_inputs();
    chk("ld_wb_data", wb_mem_data, 32'hDEAD_BEEF);
    chk("ld_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("ld_wb_dest", {27'd0, wb_dest_reg}, 32'd5);
    chk("ld_req_drop", {31'd0, m_req}, 32'd0);
    tick();
    chk("ld_wb_once", {31'd0, wb_reg_write}, 32'd0);

    // Store then ALU op
    mem_mem_write = 1'b1; mem_alu_result = 32'h0000_0200; mem_reg_read2 = 32'h1234_5678;
    tick();
    chk("st_m_we", {31'd0, m_we}, 32'd1);
    chk("st_m_wdata", m_wdata, 32'h1234_5678);
    chk("st_m_addr", m_addr, 32'h0000_0200);
    m_ack = 1'b1;
    #1;
    chk("st_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    mem_reg_write = 1'b1; mem_alu_result = 32'h0000_0055; mem_dest_reg = 5'd7;
    #1;
    chk("alu_no_stall", {31'd0, stall}, 32'd0);
    chk("st_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    tick();
    idle_inputs();
    chk("alu_wb_result", wb_alu_result, 32'h0000_0055);
    chk("alu_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_m_req", {31'd0, m_req}, 32'd0);

    // LL/SC success; an invalidate during WR_WAIT does not change the result
    do_ll(32'h0000_0300, 1'b0, 30'h0);
    chk("ll_wb_data", wb_mem_data, 32'hAAAA_0001);
    set_sc(32'h0000_0300, 32'h0000_CAFE);
    #1;
    chk("sc_ok_stall", {31'd0, stall}, 32'd1);
    tick();
    idle_inputs();
    chk("sc_ok_m_req", {31'd0, m_req}, 32'd1);
    chk("sc_ok_m_we", {31'd0, m_we}, 32'd1);
    chk("sc_ok_wdata", m_wdata, 32'h0000_CAFE);
    inv_valid = 1'b1; inv_addr = 30'h0C0;
    tick();
    inv_valid = 1'b0; m_ack = 1'b1;
    tick();
    idle_inputs();
    chk("sc_ok_wb_data", wb_mem_data, 32'd1);
    chk("sc_ok_memtoreg", {31'd0, wb_memtoreg}, 32'd1);
    // Link was consumed: a second SC must fail
    set_sc(32'h0000_0300, 32'h0000_BEEF);
    #1;
    chk("sc2_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("sc2_m_req", {31'd0, m_req}, 32'd0);
    chk("sc2_wb_data", wb_mem_data, 32'd0);
    chk("sc2_memtoreg", {31'd0, wb_memtoreg}, 32'd1);

    // LL, matching invalidate, SC fails without a request
    do_ll(32'h0000_0300, 1'b0, 30'h0);
    inv_valid = 1'b1; inv_addr = 30'h0C0;
    tick();
    idle_inputs();
    set_sc(32'h0000_0300, 32'h0000_0011);
    #1;
    chk("inv_sc_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("inv_sc_m_req", {31'd0, m_req}, 32'd0);
    chk("inv_sc_wb_data", wb_mem_data, 32'd0);

    // Non-matching invalidate keeps the link
    do_ll(32'h0000_0300, 1'b0, 30'h0);
    inv_valid = 1'b1; inv_addr = 30'h0C1;
    tick();
    idle_inputs();
    set_sc(32'h0000_0300, 32'h0000_0022);
    tick();
    idle_inputs();
    chk("inv_other_m_req", {31'd0, m_req}, 32'd1);
    m_ack = 1'b1;
    tick();
    idle_inputs();
    chk("inv_other_wb_data", wb_mem_data, 32'd1);

    // Invalidate in the same cycle as the LL ack wins
    do_ll(32'h0000_0500, 1'b1, 30'h140);
    set_sc(32'h0000_0500, 32'h0000_0033);
    tick();
    idle_inputs();
    chk("inv_race_m_req", {31'd0, m_req}, 32'd0);

    // Plain store to the linked word clears the link
    do_ll(32'h0000_0600, 1'b0, 30'h0);
    mem_mem_write = 1'b1; mem_alu_result = 32'h0000_0600;
    tick();
    idle_inputs();
    m_ack = 1'b1;
    tick();
    idle_inputs();
    set_sc(32'h0000_0600, 32'h0000_0044);
    tick();
    idle_inputs();
    chk("st_clr_m_req", {31'd0, m_req}, 32'd0);

    // Reset mid-access; late ack ignored
    mem_mem_read = 1'b1; mem_alu_result = 32'h0000_0400; mem_reg_write = 1'b1;
    mem_memtoreg = 1'b1; mem_dest_reg = 5'd9;
    tick();
    chk("rma_m_req", {31'd0, m_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rma_m_req_drop", {31'd0, m_req}, 32'd0);
    chk("rma_stall", {31'd0, stall}, 32'd0);
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    tick();
    idle_inputs();
    chk("rma_no_wb", {31'd0, wb_reg_write}, 32'd0);
    chk("rma_no_data", wb_mem_data, 32'd0);

    // Branch
    mem_branch = 1'b1; mem_alu_zero = 1'b1;
    #1;
    chk("br_taken", {31'd0, branch_taken}, 32'd1);
    mem_alu_zero = 1'b0;
    #1;
    chk("br_not_taken", {31'd0, branch_taken}, 32'd0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
